// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the data-SRAM port arbiter.
//   owner_t       : which requester currently holds the SRAM (or none)
//   MAX_HOLD_DEF  : default contention hold limit, in granted cycles
//   other_port()  : the opposite requester of CPU/DBG
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam int MAX_HOLD_DEF = 4;

    function automatic owner_t other_port(input owner_t o);
        return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester ports and the SRAM port around the arbiter.
//   cpu_* / dbg_* : req/we/addr/wdata in, gnt/rvalid/rdata out (per requester)
//   sram_*        : en/we/addr/wdata to the SRAM, rdata back (1-cycle latency)
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and SRAM model's view
interface sram_port_arbiter_if #(
    parameter int N         = 8,
    parameter int ADDR_BITS = 6
);
    logic                 cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [N-1:0]         cpu_wdata, cpu_rdata;

    logic                 dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [ADDR_BITS-1:0] dbg_addr;
    logic [N-1:0]         dbg_wdata, dbg_rdata;

    logic                 sram_en, sram_we;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [N-1:0]         sram_wdata, sram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for the single-port data SRAM, shared by the CPU
// load/store path and the debug/loader port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester and SRAM signals (sram_port_arbiter_if.slave)
// Grant is combinational from registered state and the current requests, so
// an access completes on the same edge it is requested. Under contention a
// requester keeps the SRAM for at most MAX_HOLD consecutive cycles; a sole
// requester is never cut off. Read data returns one cycle after the grant,
// steered to the port that issued the read.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int ADDR_BITS = 6,
    parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_port_arbiter_if.slave  bus
);

    localparam int             HW       = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

    owner_t          owner_q, owner_d;
    owner_t          last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            rd_cpu_q, rd_cpu_d;
    logic            rd_dbg_q, rd_dbg_d;
    owner_t          win;

    // Grant decision plus next state. Reset gates the grant so every output
    // is quiet while rst_n is low, even with requests asserted.
    always_comb begin
        win = OWN_NONE;
        if (rst_n) begin
            if (bus.cpu_req && !bus.dbg_req) begin
                win = OWN_CPU;
            end else if (bus.dbg_req && !bus.cpu_req) begin
                win = OWN_DBG;
            end else if (bus.cpu_req && bus.dbg_req) begin
                if (owner_q == OWN_NONE) begin
                    win = other_port(last_q);
                end else if (hold_q < HOLD_MAX) begin
                    win = owner_q;
                end else begin
                    win = other_port(owner_q);
                end
            end
        end

        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (win == OWN_NONE) begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end else if (win == owner_q) begin
            // Saturates so a lone streamer yields at once when contention appears.
            if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
        end else begin
            owner_d = win;
            last_d  = win;
            hold_d  = HW'(1);
        end

        rd_cpu_d = (win == OWN_CPU) && !bus.cpu_we;
        rd_dbg_d = (win == OWN_DBG) && !bus.dbg_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            last_q   <= OWN_DBG;   // CPU wins the first tie
            hold_q   <= '0;
            rd_cpu_q <= 1'b0;
            rd_dbg_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            rd_cpu_q <= rd_cpu_d;
            rd_dbg_q <= rd_dbg_d;
        end
    end

    // SRAM side: mux from the winner, all zero when idle.
    always_comb begin
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        case (win)
            OWN_CPU: begin
                bus.sram_we    = bus.cpu_we;
                bus.sram_addr  = bus.cpu_addr;
                bus.sram_wdata = bus.cpu_wdata;
            end
            OWN_DBG: begin
                bus.sram_we    = bus.dbg_we;
                bus.sram_addr  = bus.dbg_addr;
                bus.sram_wdata = bus.dbg_wdata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt    = (win == OWN_CPU);
    assign bus.dbg_gnt    = (win == OWN_DBG);
    assign bus.sram_en    = bus.cpu_gnt | bus.dbg_gnt;

    assign bus.cpu_rvalid = rd_cpu_q;
    assign bus.dbg_rvalid = rd_dbg_q;
    assign bus.cpu_rdata  = rd_cpu_q ? bus.sram_rdata : '0;
    assign bus.dbg_rdata  = rd_dbg_q ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.N(8), .ADDR_BITS(6)) bus ();

    sram_port_arbiter #(.N(8), .ADDR_BITS(6), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port SRAM, read data one cycle after the strobe.
    logic [7:0] mem [64];
    initial bus.sram_rdata = 8'h00;
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive point: 2 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [5:0] a, input logic [7:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic dbg(input logic req, input logic we, input logic [5:0] a, input logic [7:0] d);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        // ---- Reset with both requesting ----
        cpu(1, 0, 6'd3, 8'h00);
        dbg(1, 0, 6'd4, 8'h00);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("rst_cpu_gnt", bus.cpu_gnt, 0);
            chk("rst_dbg_gnt", bus.dbg_gnt, 0);
            chk("rst_sram_en", bus.sram_en, 0);
            chk("rst_sram_addr", bus.sram_addr, 0);
            chk("rst_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
        end
        tick(); rst_n = 1'b1; #1;
        chk("rel_cpu_first", bus.cpu_gnt, 1);
        chk("rel_dbg_off", bus.dbg_gnt, 0);
        chk("rel_sram_addr", bus.sram_addr, 3);
        tick(); cpu(0, 0, 0, 0); dbg(0, 0, 0, 0); #1;
        tick(); #1;

        // ---- CPU alone: write addr0=02, read back ----
        tick(); cpu(1, 1, 6'd0, 8'h02); #1;
        chk("wr_cpu_gnt", bus.cpu_gnt, 1);
        chk("wr_sram_en", bus.sram_en, 1);
        chk("wr_sram_we", bus.sram_we, 1);
        chk("wr_sram_addr", bus.sram_addr, 0);
        chk("wr_sram_wdata", bus.sram_wdata, 8'h02);
        tick(); cpu(1, 0, 6'd0, 8'h00); #1;
        chk("rd_cpu_gnt", bus.cpu_gnt, 1);
        chk("rd_sram_we", bus.sram_we, 0);
        chk("wr_no_rvalid", bus.cpu_rvalid, 0);
        tick(); cpu(0, 0, 0, 0); #1;
        chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("rd_cpu_rdata", bus.cpu_rdata, 8'h02);
        chk("rd_dbg_rvalid", bus.dbg_rvalid, 0);
        chk("idle_sram_en", bus.sram_en, 0);
        tick(); #1;
        chk("rd_rvalid_once", bus.cpu_rvalid, 0);
        chk("rd_rdata_zero", bus.cpu_rdata, 0);

        // ---- DBG alone streams 10 writes ----
        for (int i = 0; i < 10; i++) begin
            tick(); dbg(1, 1, 6'(i), 8'(i + 2)); #1;
            chk("dbg_stream_gnt", bus.dbg_gnt, 1);
            chk("dbg_stream_cpu", bus.cpu_gnt, 0);
            chk("dbg_stream_addr", bus.sram_addr, 32'(i));
        end
        tick(); dbg(0, 0, 0, 0); #1;
        tick(); #1;

        // ---- Both rise from idle, CPU drops after one grant ----
        tick(); cpu(1, 0, 6'd1, 0); dbg(1, 0, 6'd2, 0); #1;
        chk("tie_cpu_first", bus.cpu_gnt, 1);
        chk("tie_dbg_wait", bus.dbg_gnt, 0);
        tick(); cpu(0, 0, 0, 0); #1;
        chk("tie_dbg_next", bus.dbg_gnt, 1);
        chk("tie_cpu_off", bus.cpu_gnt, 0);
        chk("tie_cpu_rvalid", bus.cpu_rvalid, 1);
        tick(); dbg(0, 0, 0, 0); #1;
        chk("tie_dbg_rvalid", bus.dbg_rvalid, 1);
        chk("tie_cpu_rv_off", bus.cpu_rvalid, 0);
        tick(); #1;

        // ---- Continuous contention: CPUx4, DBGx4, CPUx4 ----
        tick(); cpu(1, 0, 6'd0, 0); dbg(1, 0, 6'd1, 0);
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("hold_cpu_gnt", bus.cpu_gnt, (i < 4 || i >= 8) ? 1 : 0);
            chk("hold_dbg_gnt", bus.dbg_gnt, (i >= 4 && i < 8) ? 1 : 0);
            chk("hold_excl", bus.cpu_gnt & bus.dbg_gnt, 0);
            tick();
        end
        cpu(0, 0, 0, 0); dbg(0, 0, 0, 0); #1;
        tick(); #1;

        // ---- Read back SRAM[0..5] through the CPU port ----
        for (int i = 0; i < 6; i++) begin
            tick(); cpu(1, 0, 6'(i), 0); #1;
            chk("rb_cpu_gnt", bus.cpu_gnt, 1);
            if (i > 0) begin
                chk("rb_rvalid", bus.cpu_rvalid, 1);
                chk("rb_rdata", bus.cpu_rdata, 32'(i + 1));
            end
        end
        tick(); cpu(0, 0, 0, 0); #1;
        chk("rb_last_rvalid", bus.cpu_rvalid, 1);
        chk("rb_last_rdata", bus.cpu_rdata, 8'h07);
        tick(); #1;

        // ---- Reset during a pending read ----
        tick(); cpu(1, 0, 6'd1, 0); #1;
        chk("mr_cpu_gnt", bus.cpu_gnt, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; cpu(0, 0, 0, 0); #1;
        chk("mr_rvalid_dropped", bus.cpu_rvalid, 0);
        chk("mr_rdata_zero", bus.cpu_rdata, 0);
        tick(); #1;
        chk("mr_rvalid_in_rst", bus.cpu_rvalid, 0);
        tick(); rst_n = 1'b1; cpu(1, 0, 6'd2, 0); dbg(1, 0, 6'd3, 0); #1;
        chk("mr_rvalid_after", bus.cpu_rvalid, 0);
        chk("mr_cpu_first", bus.cpu_gnt, 1);
        chk("mr_dbg_wait", bus.dbg_gnt, 0);
        tick(); cpu(0, 0, 0, 0); dbg(0, 0, 0, 0); #1;
        tick(); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Arbitrates the single-port data SRAM of microprocessor_n_memory between two requesters: the CPU load/store path and a debug/loader port used to preload or dump SRAM contents, e.g. checking locations 0..5 after a program run. Round-robin with a bounded hold limit, so a streaming requester cannot starve the other. Sits between both requesters and the SRAM instance. It owns the SRAM enable, write-enable, address and write-data lines, and returns read data with a valid strobe.

Parameters:
N, 8, data width of SRAM words
ADDR_BITS, 6, SRAM address width
MAX_HOLD, 4, max consecutive granted cycles for one requester while the other is requesting (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_BITS  CPU address
cpu_wdata  in  N  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  N  CPU read data
dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/ADDR_BITS/N  debug port, same meaning as CPU
dbg_gnt / dbg_rvalid / dbg_rdata  out  1/1/N  debug port, same meaning as CPU
sram_en  out  1  SRAM access strobe
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_BITS  SRAM address
sram_wdata  out  N  SRAM write data
sram_rdata  in  N  SRAM read data, valid one cycle after a read strobe

Behaviour:
- State registers: owner (NONE/CPU/DBG), last_grant (CPU/DBG), hold_cnt (saturating, clog2(MAX_HOLD)+1 bits), rd_pend_cpu, rd_pend_dbg.
- Reset (rst_n low, asynchronous): owner=NONE, last_grant=DBG (CPU wins the first tie), hold_cnt=0, rd_pend_*=0. While rst_n is low, every output is 0, including gnt, rvalid, rdata, sram_en, sram_we, sram_addr and sram_wdata.
- Grant is combinational from the registered state and current reqs. An access completes on the rising edge where req&&gnt. There is no idle bubble between owners.
- Grant rules, evaluated each cycle:
  - Only one req high: grant it.
  - Both high, owner holds one and hold_cnt < MAX_HOLD: keep the owner.
  - Both high, owner holds one and hold_cnt == MAX_HOLD: grant the other requester.
  - Both high, owner NONE: grant the requester opposite last_grant.
  - Neither high: no grant, sram_en=0.
- On each edge:
  - Grant to the same owner: hold_cnt+1, saturating at MAX_HOLD.
  - Grant to a new owner: owner=new, hold_cnt=1, last_grant=new.
  - No grant: owner=NONE, hold_cnt=0.
- The hold limit applies only under contention. A sole requester is granted every cycle indefinitely.
- At most one gnt is high per cycle. sram_en = cpu_gnt|dbg_gnt. sram_we, sram_addr and sram_wdata are muxed from the granted port and are 0 when idle.
- Read return: a granted read sets rd_pend_x for exactly one cycle. In that cycle x_rvalid=1 and x_rdata=sram_rdata. Otherwise x_rdata=0. Writes produce no rvalid.
- Back-to-back reads may interleave owners. Each rvalid goes only to the port that issued the read one cycle earlier.
- Requesters hold we/addr/wdata stable while req=1 and gnt=0. Dropping req before grant is legal; nothing is issued.
- Reset asserted mid-operation: a pending read is discarded (no rvalid after reset), and arbitration restarts with CPU priority.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_DBG}
  - default MAX_HOLD constant
- No sub-module required. The grant decision is one always_comb block and the state update is one always_ff block.

Test Plan:
- Reset with both reqs=1, rst_n=0 -> all gnt, rvalid and sram_en stay 0. On release, the first grant goes to CPU.
- CPU alone writes addr 0 data 8'h02, then reads addr 0 -> cpu_gnt in the same cycle as req, sram_we=1/addr=0/wdata=8'h02. The read gives cpu_rvalid one cycle later with cpu_rdata=8'h02, and dbg_rvalid stays 0.
- Both reqs rise together from idle, CPU drops req after 1 grant -> grants are CPU, then DBG on the next cycle with no bubble.
- Both reqs held continuously, MAX_HOLD=4 -> grant sequence CPU×4, DBG×4, CPU×4, with never two gnts high in one cycle.
- DBG alone holds req for 10 cycles writing addrs 0..9 with data 2..11 -> 10 consecutive dbg_gnt. SRAM[0..5] then read back as 2..7 through the CPU port.
- CPU read granted, rst_n pulsed low in the following cycle -> cpu_rvalid never asserts. After release, owner=NONE and simultaneous reqs grant CPU first.
